// File: rtl/inst_fetch.sv
// Multi-cycle instruction fetch/sequencer: PC, IR, memory handshakes and next-PC selection.
// Optional performance counters are built when PERF_CNT_EN is defined.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] PC,
   output logic        Inst_Req_Valid,
   input  logic        Inst_Req_Ack,
   input  logic [31:0] Instruction,
   input  logic        Inst_Valid,
   output logic        Inst_Ack,
   output logic [5:0]  opcode,
   output logic [5:0]  Function,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm,
   input  logic [3:0]  PC_control,
   input  logic        zero,
   input  logic [31:0] rs_value,
   input  logic        ex_done,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IF   = 2'd1,
      S_IW   = 2'd2,
      S_EX   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc4;
   logic [31:0] br_target;
   logic [31:0] jal_target;
   logic [31:0] next_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Priority jr > jal > bne > beq > sequential
   always_comb begin
      pc4        = pc_q + 32'd4;
      br_target  = pc4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
      jal_target = {pc4[31:28], ir_q[25:0], 2'b00};
      next_pc    = pc4;
      if (PC_control[3]) begin
         next_pc = rs_value;
      end else if (PC_control[2]) begin
         next_pc = jal_target;
      end else if ((PC_control[1] && !zero) || (PC_control[0] && zero)) begin
         next_pc = br_target;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_INIT: state_d = S_IF;
         S_IF: begin
            if (Inst_Req_Ack) begin
               state_d = S_IW;
            end
         end
         S_IW: begin
            if (Inst_Valid) begin
               ir_d    = Instruction;
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (ex_done) begin
               pc_d    = next_pc;
               state_d = S_IF;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   assign PC             = pc_q;
   assign Inst_Req_Valid = (state_q == S_IF);
   assign Inst_Ack       = (state_q == S_IW);
   assign opcode         = ir_q[31:26];
   assign rs             = ir_q[25:21];
   assign rt             = ir_q[20:16];
   assign rd             = ir_q[15:11];
   assign shamt          = ir_q[10:6];
   assign Function       = ir_q[5:0];
   assign imm            = ir_q[15:0];

`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] retired_cnt_q, retired_cnt_d;
   logic        retire;

   assign retire = (state_q == S_EX) && ex_done;

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q + 32'd1;
      retired_cnt_d = retired_cnt_q;
      if (retire) begin
         retired_cnt_d = retired_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q   <= '0;
         retired_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign retired_cnt = retired_cnt_q;
`else
   assign cycle_cnt   = '0;
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: transaction-level model, directed cases and random traffic.
module tb_inst_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC;
   logic        Inst_Req_Valid;
   logic        Inst_Req_Ack;
   logic [31:0] Instruction;
   logic        Inst_Valid;
   logic        Inst_Ack;
   logic [5:0]  opcode;
   logic [5:0]  Function;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [3:0]  PC_control;
   logic        zero;
   logic [31:0] rs_value;
   logic        ex_done;
   logic [31:0] cycle_cnt;
   logic [31:0] retired_cnt;

   int tests = 0;
   int fails = 0;

   inst_fetch #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
      .Inst_Req_Ack(Inst_Req_Ack), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
      .Inst_Ack(Inst_Ack), .opcode(opcode), .Function(Function), .rs(rs), .rt(rt),
      .rd(rd), .shamt(shamt), .imm(imm), .PC_control(PC_control), .zero(zero),
      .rs_value(rs_value), .ex_done(ex_done), .cycle_cnt(cycle_cnt),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which handshake the unit is waiting on, plus PC/IR/counters.
   // phase: 0 boot, 1 requesting, 2 awaiting word, 3 executing
   int          m_phase;
   logic [31:0] m_pc, m_ir, m_cyc, m_ret;

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                              input logic [3:0] pcc, input logic z,
                                              input logic [31:0] rsv);
      logic [31:0]        seq;
      logic signed [15:0] simm;
      int                 off;
      seq  = pc + 32'd4;
      simm = ir[15:0];
      off  = int'(simm) * 4;
      if (pcc[3]) return rsv;
      if (pcc[2]) return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
      if ((pcc[1] && !z) || (pcc[0] && z)) return seq + 32'(off);
      return seq;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_pc    <= RST_PC;
         m_ir    <= '0;
         m_cyc   <= '0;
         m_ret   <= '0;
      end else begin
         m_cyc <= m_cyc + 32'd1;
         if (m_phase == 0) begin
            m_phase <= 1;
         end else if (m_phase == 1) begin
            if (Inst_Req_Ack) m_phase <= 2;
         end else if (m_phase == 2) begin
            if (Inst_Valid) begin
               m_ir    <= Instruction;
               m_phase <= 3;
            end
         end else begin
            if (ex_done) begin
               m_pc    <= model_next(m_pc, m_ir, PC_control, zero, rs_value);
               m_ret   <= m_ret + 32'd1;
               m_phase <= 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("pc", PC, m_pc);
      check("req_valid", {31'd0, Inst_Req_Valid}, {31'd0, m_phase == 1});
      check("inst_ack", {31'd0, Inst_Ack}, {31'd0, m_phase == 2});
      check("opcode", {26'd0, opcode}, m_ir >> 26);
      check("function", {26'd0, Function}, m_ir & 32'h3F);
      check("rs", {27'd0, rs}, (m_ir >> 21) & 32'h1F);
      check("rt", {27'd0, rt}, (m_ir >> 16) & 32'h1F);
      check("rd", {27'd0, rd}, (m_ir >> 11) & 32'h1F);
      check("shamt", {27'd0, shamt}, (m_ir >> 6) & 32'h1F);
      check("imm", {16'd0, imm}, m_ir & 32'hFFFF);
`ifdef PERF_CNT_EN
      check("cycle_cnt", cycle_cnt, m_cyc);
      check("retired_cnt", retired_cnt, m_ret);
`else
      check("cycle_cnt_off", cycle_cnt, 32'd0);
      check("retired_cnt_off", retired_cnt, 32'd0);
`endif
   end

   task automatic wait_req();
      Inst_Req_Ack = 1'b0;
      for (int i = 0; i < 50 && !Inst_Req_Valid; i++) @(negedge clk);
      if (!Inst_Req_Valid) check("req_wait_timeout", {31'd0, Inst_Req_Valid}, 32'd1);
   endtask

   // Leaves the unit in execute with instr latched; noise on ignored inputs while holding.
   task automatic fetch(input logic [31:0] instr, input int ack_dly, input int val_dly);
      wait_req();
      for (int i = 0; i < ack_dly; i++) begin
         Inst_Req_Ack = 1'b0; Inst_Valid = 1'b1; ex_done = 1'b1; Instruction = $urandom;
         @(negedge clk);
      end
      Inst_Req_Ack = 1'b1; Inst_Valid = 1'b0; ex_done = 1'b0;
      @(negedge clk);
      Inst_Req_Ack = 1'b0;
      for (int i = 0; i < val_dly; i++) begin
         Instruction = $urandom; ex_done = 1'b1;
         @(negedge clk);
      end
      ex_done = 1'b0; Instruction = instr; Inst_Valid = 1'b1;
      @(negedge clk);
      Inst_Valid = 1'b0; Instruction = $urandom;
   endtask

   task automatic execute(input logic [3:0] pcc, input logic z, input logic [31:0] rsv);
      PC_control = pcc; zero = z; rs_value = rsv; ex_done = 1'b1;
      @(negedge clk);
      ex_done = 1'b0; PC_control = 4'($urandom_range(0, 15)); zero = 1'($urandom);
      rs_value = $urandom;
   endtask

   task automatic run_inst(input logic [31:0] instr, input logic [3:0] pcc, input logic z,
                           input logic [31:0] rsv, input int ack_dly, input int val_dly);
      fetch(instr, ack_dly, val_dly);
      execute(pcc, z, rsv);
   endtask

   initial begin
      rst = 1'b1;
      Inst_Req_Ack = 1'b0; Instruction = '0; Inst_Valid = 1'b0;
      PC_control = '0; zero = 1'b0; rs_value = '0; ex_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("boot_req_init", {31'd0, Inst_Req_Valid}, 32'd0);
      @(negedge clk);
      check("boot_req_if", {31'd0, Inst_Req_Valid}, 32'd1);
      check("boot_pc", PC, 32'h0);

      fetch(32'h0085_1021, 0, 0);
      check("t2_opcode", {26'd0, opcode}, 32'h0);
      check("t2_function", {26'd0, Function}, 32'h21);
      check("t2_rs", {27'd0, rs}, 32'd4);
      check("t2_rt", {27'd0, rt}, 32'd5);
      check("t2_rd", {27'd0, rd}, 32'd2);
      execute(4'b0000, 1'b0, 32'h0);
      check("t2_pc", PC, 32'h4);
      check("t2_req", {31'd0, Inst_Req_Valid}, 32'd1);

      #2 rst = 1'b1;
      #1;
      check("t1_pc", PC, RST_PC);
      check("t1_req", {31'd0, Inst_Req_Valid}, 32'd0);
      check("t1_opcode", {26'd0, opcode}, 32'd0);
      check("t1_function", {26'd0, Function}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 3; i++) run_inst(32'h0, 4'b0000, 1'b0, 32'h0, 0, 0);
      check("seq_pc", PC, 32'hC);
`ifdef PERF_CNT_EN
      check("perf_retired", retired_cnt, 32'd3);
      check("perf_cycles_ge10", {31'd0, cycle_cnt >= 32'd10}, 32'd1);
`endif
      run_inst(32'h0, 4'b0000, 1'b0, 32'h0, 0, 0);
      check("t3_start", PC, 32'h10);
      run_inst({6'd4, 5'd1, 5'd2, 16'hFFFF}, 4'b0001, 1'b1, 32'h0, 0, 0);
      check("t3_beq_taken", PC, 32'h10);
      run_inst({6'd4, 5'd1, 5'd2, 16'hFFFF}, 4'b0001, 1'b0, 32'h0, 0, 0);
      check("t3_beq_not", PC, 32'h14);
      run_inst({6'd5, 5'd1, 5'd2, 16'hFFFE}, 4'b0010, 1'b0, 32'h0, 0, 0);
      check("t3_bne_taken", PC, 32'h10);
      run_inst({6'd5, 5'd1, 5'd2, 16'hFFFE}, 4'b0010, 1'b1, 32'h0, 0, 0);
      check("t3_bne_not", PC, 32'h14);

      run_inst({6'd0, 5'd31, 15'd0, 6'h08}, 4'b1000, 1'b0, 32'h0040_0000, 0, 0);
      check("t4_jr_setup", PC, 32'h0040_0000);
      run_inst({6'd3, 26'h100}, 4'b0100, 1'b0, 32'h0, 0, 0);
      check("t4_jal", PC, 32'h0000_0400);
      run_inst({6'd0, 5'd8, 15'd0, 6'h08}, 4'b1000, 1'b0, 32'h1238, 0, 0);
      check("t4_jr", PC, 32'h1238);
      run_inst({6'd4, 5'd1, 5'd2, 16'h0010}, 4'b1001, 1'b1, 32'h2000, 0, 0);
      check("t4_jr_beats_beq", PC, 32'h2000);
      run_inst(32'h0, 4'b1000, 1'b0, 32'hFFFF_FFFC, 0, 0);
      run_inst(32'h0, 4'b0000, 1'b0, 32'h0, 0, 0);
      check("pc_wrap", PC, 32'h0);

      fetch(32'h8C43_0010, 5, 3);
      check("t5_opcode", {26'd0, opcode}, 32'h23);
      check("t5_imm", {16'd0, imm}, 32'h10);
      execute(4'b0000, 1'b0, 32'h0);
      check("t5_pc", PC, 32'h4);

      wait_req();
      Inst_Req_Ack = 1'b1;
      @(negedge clk);
      Inst_Req_Ack = 1'b0;
      check("t6_in_iw", {31'd0, Inst_Ack}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_ack_drop", {31'd0, Inst_Ack}, 32'd0);
      check("t6_pc", PC, RST_PC);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         Inst_Req_Ack = 1'($urandom);
         Inst_Valid   = 1'($urandom);
         Instruction  = $urandom;
         ex_done      = ($urandom_range(0, 2) == 0);
         PC_control   = 4'($urandom_range(0, 15));
         zero         = 1'($urandom);
         rs_value     = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
